// File: rtl/pp_pipeline_accel_udiv_31ns_11ns_20_iter.sv
// Iterative restoring divider: a 31-bit dividend by an 11-bit divisor, one quotient bit per ce-enabled clock.
// The quotient saturates to 20 bits, and the block flags overflow and divide-by-zero.
module pp_pipeline_accel_udiv_31ns_11ns_20_iter #(
    parameter logic [31:0] ID = 32'd1
) (
    input  logic        ap_clk,
    input  logic        ap_rst_n,
    input  logic        ce,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [30:0] dividend,
    input  logic [10:0] divisor,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [19:0] quot,
    output logic [10:0] rem,
    output logic        ovf,
    output logic        dbz
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q;
    logic [30:0] dvd_q;
    logic [10:0] dvs_q;
    logic [11:0] prem_q;
    logic [30:0] quo_q;

    logic [11:0] shifted;
    logic        ge;
    logic [11:0] prem_nx;
    logic [30:0] quo_nx;
    logic        last;
    logic        unused_ok;

    // The partial remainder stays below the divisor, so its top bit is always 0 before the shift.
    assign shifted   = {prem_q[10:0], dvd_q[30]};
    assign ge        = shifted >= {1'b0, dvs_q};
    assign prem_nx   = ge ? shifted - {1'b0, dvs_q} : shifted;
    assign quo_nx    = {quo_q[29:0], ge};
    assign last      = (cnt_q == 5'd0);
    assign unused_ok = ^{ID, prem_q[11]};

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);

    always_comb begin
        // NOTE: state_d gets a default before the case, so no path leaves it unassigned and no latch is inferred.
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)  state_d = BUSY;
            BUSY:    if (last)      state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values.
        if (!ap_rst_n) state_q <= IDLE;
        else if (ce)   state_q <= state_d;
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            cnt_q  <= 5'd0;
            dvd_q  <= '0;
            dvs_q  <= '0;
            prem_q <= '0;
            quo_q  <= '0;
            quot   <= '0;
            rem    <= '0;
            ovf    <= 1'b0;
            dbz    <= 1'b0;
        end else if (ce) begin
            case (state_q)
                IDLE: if (in_valid) begin
                    dvd_q  <= dividend;
                    dvs_q  <= divisor;
                    cnt_q  <= 5'd30;
                    prem_q <= '0;
                    quo_q  <= '0;
                end
                BUSY: begin
                    dvd_q  <= {dvd_q[29:0], 1'b0};
                    prem_q <= prem_nx;
                    quo_q  <= quo_nx;
                    if (!last) begin
                        cnt_q <= cnt_q - 5'd1;
                    end else if (dvs_q == 11'd0) begin
                        quot <= 20'hFFFFF;
                        rem  <= 11'd0;
                        ovf  <= 1'b0;
                        dbz  <= 1'b1;
                    end else if (|quo_nx[30:20]) begin
                        quot <= 20'hFFFFF;
                        rem  <= prem_nx[10:0];
                        ovf  <= 1'b1;
                        dbz  <= 1'b0;
                    end else begin
                        quot <= quo_nx[19:0];
                        rem  <= prem_nx[10:0];
                        ovf  <= 1'b0;
                        dbz  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pp_pipeline_accel_udiv_31ns_11ns_20_iter.sv
// Randomized self-checking bench for the iterative divider.
// Expected results come from plain integer division with saturation rules.
module tb_pp_pipeline_accel_udiv_31ns_11ns_20_iter;

    logic        ap_clk = 1'b0;
    logic        ap_rst_n = 1'b0;
    logic        ce = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [30:0] dividend = '0;
    logic [10:0] divisor = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [19:0] quot;
    logic [10:0] rem;
    logic        ovf;
    logic        dbz;

    int total = 0;
    int bad = 0;

    pp_pipeline_accel_udiv_31ns_11ns_20_iter #(.ID(32'd1)) dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ce(ce),
        .in_valid(in_valid), .in_ready(in_ready),
        .dividend(dividend), .divisor(divisor),
        .out_valid(out_valid), .out_ready(out_ready),
        .quot(quot), .rem(rem), .ovf(ovf), .dbz(dbz)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model(input logic [30:0] a, input logic [10:0] b,
                         output logic [19:0] q, output logic [10:0] r,
                         output logic o, output logic z);
        longint unsigned qa;
        if (b == 11'd0) begin
            q = 20'hFFFFF; r = 11'd0; o = 1'b0; z = 1'b1;
        end else begin
            qa = longint'(a) / longint'(b);
            r  = 11'(longint'(a) % longint'(b));
            z  = 1'b0;
            if (qa >= 64'd1048576) begin
                q = 20'hFFFFF; o = 1'b1;
            end else begin
                q = 20'(qa); o = 1'b0;
            end
        end
    endtask

    // Launch one division, optionally stalling ce for gap_len cycles and holding out_ready low.
    task automatic run_op(input logic [30:0] a, input logic [10:0] b,
                          input int gap_at, input int gap_len, input int hold);
        logic [19:0] eq;
        logic [10:0] er;
        logic        eo, ez;
        int          n;
        model(a, b, eq, er, eo, ez);
        @(negedge ap_clk);
        check("in_ready_idle", 32'(in_ready), 32'd1);
        ce = 1'b1; in_valid = 1'b1; dividend = a; divisor = b;
        out_ready = (hold == 0);
        @(negedge ap_clk);
        in_valid = 1'b0;
        dividend = 31'($urandom);
        divisor  = 11'($urandom);
        n = 0;
        while (!out_valid && n < 200) begin
            ce = !(n >= gap_at && n < gap_at + gap_len);
            in_valid = 1'($urandom);
            @(negedge ap_clk);
            n++;
        end
        ce = 1'b1; in_valid = 1'b0;
        check("latency", 32'(n), 32'(31 + gap_len));
        check("quot", 32'(quot), 32'(eq));
        check("rem", 32'(rem), 32'(er));
        check("ovf", 32'(ovf), 32'(eo));
        check("dbz", 32'(dbz), 32'(ez));
        check("in_ready_done", 32'(in_ready), 32'd0);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            dividend = 31'($urandom);
            divisor  = 11'($urandom);
            @(negedge ap_clk);
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_quot", 32'(quot), 32'(eq));
            check("hold_rem", 32'(rem), 32'(er));
            check("hold_flags", {30'd0, ovf, dbz}, {30'd0, eo, ez});
            check("hold_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge ap_clk);
        check("release_valid", 32'(out_valid), 32'd0);
        check("release_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        int seen;
        logic [10:0] b;
        logic [30:0] a;

        repeat (2) @(negedge ap_clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_outputs", {quot, rem, ovf}, 32'd0);
        check("rst_dbz", 32'(dbz), 32'd0);
        ap_rst_n = 1'b1;

        run_op(31'd12345, 11'd7, 0, 0, 0);
        run_op(31'd2147483647, 11'd2047, 0, 0, 0);
        run_op(31'd1000000, 11'd0, 0, 0, 0);
        run_op(31'd99999, 11'd13, 0, 0, 10);
        run_op(31'd1000000, 11'd1000, 10, 5, 0);

        // Abort an operation mid-BUSY with a reset pulse that lands between edges.
        @(negedge ap_clk);
        in_valid = 1'b1; dividend = 31'd1000000; divisor = 11'd1000;
        @(negedge ap_clk);
        in_valid = 1'b0;
        repeat (15) @(negedge ap_clk);
        #2 ap_rst_n = 1'b0;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_in_ready", 32'(in_ready), 32'd1);
        check("arst_outputs", {quot, rem, ovf}, 32'd0);
        check("arst_dbz", 32'(dbz), 32'd0);
        #1 ap_rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge ap_clk);
            if (out_valid) seen++;
        end
        check("aborted_no_result", 32'(seen), 32'd0);
        run_op(31'd65535, 11'd255, 0, 0, 0);

        for (int k = 0; k < 40; k++) begin
            b = ($urandom_range(0, 9) == 0) ? 11'd0 : 11'($urandom);
            a = 31'($urandom) >> $urandom_range(0, 30);
            run_op(a, b, $urandom_range(0, 25), $urandom_range(0, 4), $urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
